// File: rtl/sram_access_ctrl_if.sv
// Request/response and SRAM-side signals of the SRAM access controller.
// The controller uses the slave modport. The master modport is for the
// environment, which is both the requester and the SRAM, so it also drives
// sram_rdata.
interface sram_access_ctrl_if #(
  parameter int ADDR_W = 26,
  parameter int DATA_W = 16
);
  logic              req;
  logic              req_mode;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic              busy;
  logic              ack;
  logic [DATA_W-1:0] rd_data;
  logic              calc_enable;
  logic              calc_mode;
  logic              row_read_done;
  logic              row_write_done;
  logic              sram_read_enable;
  logic              sram_write_enable;
  logic [ADDR_W-1:0] sram_addr;
  logic [DATA_W-1:0] sram_wdata;
  logic [DATA_W-1:0] sram_rdata;

  modport master (
    output req, req_mode, req_addr, req_wdata, sram_rdata,
    input  busy, ack, rd_data, calc_enable, calc_mode, row_read_done,
           row_write_done, sram_read_enable, sram_write_enable, sram_addr,
           sram_wdata
  );

  modport slave (
    input  req, req_mode, req_addr, req_wdata, sram_rdata,
    output busy, ack, rd_data, calc_enable, calc_mode, row_read_done,
           row_write_done, sram_read_enable, sram_write_enable, sram_addr,
           sram_wdata
  );
endinterface

// File: rtl/sram_access_ctrl.sv
// SRAM access controller: single-word read/write responder.
// - Holds the read or write strobe for a fixed latency and then pulses ack.
//   The ack doubles as the advance pulse for the address calculator.
// - Counts completed reads and completed writes per image row, and flags the
//   last access of each row.
module sram_access_ctrl #(
  parameter int ADDR_W = 26,
  parameter int DATA_W = 16,
  parameter int RD_LAT = 2,
  parameter int WR_LAT = 1
) (
  input  logic        clk,
  input  logic        n_rst,
  input  logic        clear,
  input  logic [12:0] image_width,
  sram_access_ctrl_if.slave bus
);
  localparam int MAX_LAT = (RD_LAT > WR_LAT) ? RD_LAT : WR_LAT;
  localparam int LAT_W   = $clog2(MAX_LAT + 1);

  typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_WAIT, ST_DONE} state_t;

  state_t            state_reg;
  state_t            state_next;
  logic              mode_reg;
  logic [ADDR_W-1:0] addr_reg;
  logic [DATA_W-1:0] wdata_reg;
  logic [DATA_W-1:0] rd_data_reg;
  logic [LAT_W-1:0]  lat_cnt_reg;
  logic [LAT_W-1:0]  issue_lat;
  logic              accept;
  logic              last_strobe;
  logic              complete;
  logic              strobe;
  logic [1:0]        row_done;

  // Latency of the transaction that was latched.
  assign issue_lat = mode_reg ? LAT_W'(RD_LAT) : LAT_W'(WR_LAT);

  // Next state, request acceptance, and detection of the last strobe cycle.
  // clear wins over everything, including a request in the same cycle.
  always_comb begin
    state_next  = state_reg;
    accept      = 1'b0;
    last_strobe = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (bus.req) begin
          accept     = 1'b1;
          state_next = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        last_strobe = (issue_lat == LAT_W'(1));
        state_next  = last_strobe ? ST_DONE : ST_WAIT;
      end
      ST_WAIT: begin
        last_strobe = (lat_cnt_reg == LAT_W'(1));
        if (last_strobe) begin
          state_next = ST_DONE;
        end
      end
      ST_DONE: begin
        if (bus.req) begin
          accept     = 1'b1;
          state_next = ST_ISSUE;
        end else begin
          state_next = ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
    if (clear) begin
      state_next = ST_IDLE;
      accept     = 1'b0;
    end
  end

  // An access completes only if it is not aborted on its last strobe cycle.
  assign complete = last_strobe && !clear;

  // State register.
  always_ff @(posedge clk) begin
    if (!n_rst) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Request latch, latency countdown, and read-data capture.
  // The read word is captured on the last strobe cycle; an aborted read
  // leaves rd_data unchanged.
  always_ff @(posedge clk) begin
    if (!n_rst) begin
      mode_reg    <= 1'b0;
      addr_reg    <= '0;
      wdata_reg   <= '0;
      rd_data_reg <= '0;
      lat_cnt_reg <= '0;
    end else begin
      if (accept) begin
        mode_reg  <= bus.req_mode;
        addr_reg  <= bus.req_addr;
        wdata_reg <= bus.req_wdata;
      end
      if (state_reg == ST_ISSUE) begin
        lat_cnt_reg <= issue_lat - LAT_W'(1);
      end else if (state_reg == ST_WAIT) begin
        lat_cnt_reg <= lat_cnt_reg - LAT_W'(1);
      end
      if (complete && mode_reg) begin
        rd_data_reg <= bus.sram_rdata;
      end
    end
  end

  // Row counters.
  // - Index 0 counts reads against image_width.
  // - Index 1 counts writes against image_width-1.
  // - A modulus of 0 disables the flag; the counter then wraps at 2^13.
  for (genvar gi = 0; gi < 2; gi++) begin : g_row
    localparam logic IS_READ = (gi == 0);
    logic [12:0] modulus;
    logic [13:0] cnt_inc;
    logic        hit;
    logic [12:0] cnt_reg;
    logic        done_reg;

    if (gi == 0) begin : g_mod_rd
      assign modulus = image_width;
    end else begin : g_mod_wr
      assign modulus = (image_width <= 13'd1) ? 13'd0 : image_width - 13'd1;
    end

    assign cnt_inc = {1'b0, cnt_reg} + 14'd1;
    assign hit     = (modulus != 13'd0) && (cnt_inc >= {1'b0, modulus});

    // Advance on completion of this direction's access.
    // The end-of-row flag lines up with ack.
    always_ff @(posedge clk) begin
      if (!n_rst || clear) begin
        cnt_reg  <= '0;
        done_reg <= 1'b0;
      end else begin
        done_reg <= 1'b0;
        if (complete && (mode_reg == IS_READ)) begin
          if (hit) begin
            cnt_reg  <= '0;
            done_reg <= 1'b1;
          end else begin
            cnt_reg <= cnt_inc[12:0];
          end
        end
      end
    end

    assign row_done[gi] = done_reg;
  end

  assign strobe                = (state_reg == ST_ISSUE) || (state_reg == ST_WAIT);
  assign bus.busy              = strobe;
  assign bus.sram_read_enable  = strobe && mode_reg;
  assign bus.sram_write_enable = strobe && !mode_reg;
  assign bus.sram_addr         = addr_reg;
  assign bus.sram_wdata        = wdata_reg;
  assign bus.ack               = (state_reg == ST_DONE);
  assign bus.calc_enable       = (state_reg == ST_DONE);
  assign bus.calc_mode         = mode_reg;
  assign bus.rd_data           = rd_data_reg;
  assign bus.row_read_done     = row_done[0];
  assign bus.row_write_done    = row_done[1];
endmodule

// File: tb/tb_sram_access_ctrl.sv
// Testbench for sram_access_ctrl.
// - Stimulus: a table of directed accesses, hand-written multi-cycle corner
//   sequences, and a randomized stream.
// - Expected values come from a transaction-level model: per-direction row
//   counts and the last read word.
module tb_sram_access_ctrl;
  localparam int RD_LAT = 2;
  localparam int WR_LAT = 1;

  logic        clk = 1'b0;
  logic        n_rst;
  logic        clear;
  logic [12:0] image_width;

  sram_access_ctrl_if #(.ADDR_W(26), .DATA_W(16)) bus ();

  sram_access_ctrl #(
    .ADDR_W(26), .DATA_W(16), .RD_LAT(RD_LAT), .WR_LAT(WR_LAT)
  ) dut (
    .clk(clk), .n_rst(n_rst), .clear(clear), .image_width(image_width),
    .bus(bus.slave)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  int n_xact = 0;
  int m_rd_cnt = 0;
  int m_wr_cnt = 0;
  logic [15:0] m_rd_data = 16'h0;

  // SRAM contents as a function of the address.
  function automatic logic [15:0] model_word(input logic [25:0] a);
    logic [15:0] t;
    if (a == 26'd440) return 16'hBEEF;
    t = a[15:0] * 16'd7;
    return t ^ 16'h1234;
  endfunction

  // SRAM model: the word is valid only on the last cycle of a read strobe.
  int rd_run = 0;
  always @(posedge clk) rd_run <= (bus.sram_read_enable === 1'b1) ? rd_run + 1 : 0;
  always_comb begin
    bus.sram_rdata = 16'hDEAD;
    if (bus.sram_read_enable === 1'b1 && rd_run == RD_LAT - 1)
      bus.sram_rdata = model_word(bus.sram_addr);
  end

  // Row rule: a completion advances the count, and the flag fires when the
  // count reaches the modulus.
  function automatic logic row_step(input logic mode, input int width);
    int m;
    int c;
    m = mode ? width : ((width <= 1) ? 0 : width - 1);
    c = mode ? m_rd_cnt : m_wr_cnt;
    row_step = 1'b0;
    c = c + 1;
    if (m != 0 && c >= m) begin
      row_step = 1'b1;
      c = 0;
    end else begin
      c = c % 8192;
    end
    if (mode) m_rd_cnt = c; else m_wr_cnt = c;
  endfunction

  task automatic chk(input string name, input longint act, input longint exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  function automatic logic [39:0] ctrl_outs();
    return {bus.busy, bus.ack, bus.calc_enable, bus.calc_mode, bus.row_read_done,
            bus.row_write_done, bus.sram_read_enable, bus.sram_write_enable,
            bus.rd_data, bus.sram_wdata};
  endfunction

  // One access, started at a negedge with the DUT ready (IDLE or DONE).
  // Returns at the negedge where ack is seen, with req dropped.
  task automatic access(input logic mode, input logic [25:0] addr, input logic [15:0] wdata,
                        input logic exp_rf, input logic exp_wf,
                        output logic got_rf, output logic got_wf);
    int cyc, rd_cyc, wr_cyc, bad_addr, bad_wd, bad_busy, bad_pulse, lat;
    logic seen;
    lat = mode ? RD_LAT : WR_LAT;
    cyc = 0; rd_cyc = 0; wr_cyc = 0; bad_addr = 0; bad_wd = 0; bad_busy = 0; bad_pulse = 0;
    seen = 1'b0;
    bus.req = 1'b1; bus.req_mode = mode; bus.req_addr = addr; bus.req_wdata = wdata;
    while (!seen && cyc < 20) begin
      @(negedge clk);
      cyc++;
      if (bus.ack === 1'b1) begin
        seen = 1'b1;
      end else begin
        if (bus.sram_read_enable === 1'b1) rd_cyc++;
        if (bus.sram_write_enable === 1'b1) wr_cyc++;
        if (bus.sram_addr !== addr) bad_addr++;
        if (bus.sram_write_enable === 1'b1 && bus.sram_wdata !== wdata) bad_wd++;
        if (bus.busy !== 1'b1) bad_busy++;
        if (bus.calc_enable !== 1'b0 || bus.row_read_done !== 1'b0 ||
            bus.row_write_done !== 1'b0) bad_pulse++;
        // Requests while busy must be ignored; scramble them.
        bus.req = 1'($urandom); bus.req_mode = 1'($urandom);
        bus.req_addr = 26'($urandom); bus.req_wdata = 16'($urandom);
      end
    end
    got_rf = bus.row_read_done;
    got_wf = bus.row_write_done;
    if (mode) m_rd_data = model_word(addr);
    n_xact++;
    chk("ack_seen", longint'(seen), 64'd1);
    chk("latency", longint'(cyc), longint'(lat + 1));
    chk("rd_strobe_cycles", longint'(rd_cyc), mode ? longint'(lat) : 64'd0);
    chk("wr_strobe_cycles", longint'(wr_cyc), mode ? 64'd0 : longint'(lat));
    chk("addr_stable", longint'(bad_addr), 64'd0);
    chk("wdata", longint'(bad_wd), 64'd0);
    chk("busy", longint'(bad_busy), 64'd0);
    chk("early_pulse", longint'(bad_pulse), 64'd0);
    chk("calc_enable", longint'(bus.calc_enable), 64'd1);
    chk("calc_mode", longint'(bus.calc_mode), longint'(mode));
    chk("done_strobes", longint'({bus.busy, bus.sram_read_enable, bus.sram_write_enable}), 64'd0);
    chk("rd_data", longint'(bus.rd_data), longint'(m_rd_data));
    chk("row_read_done", longint'(got_rf), longint'(exp_rf));
    chk("row_write_done", longint'(got_wf), longint'(exp_wf));
    bus.req = 1'b0;
    $display("xact %0d mode=%0d addr=%0h width=%0d lat=%0d rd_data=%0h rf=%0d wf=%0d",
             n_xact, mode, addr, image_width, cyc, bus.rd_data, got_rf, got_wf);
  endtask

  task automatic clear_pulse();
    bus.req = 1'b0;
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    m_rd_cnt = 0;
    m_wr_cnt = 0;
  endtask

  typedef struct {
    logic        mode;
    logic [25:0] addr;
    logic [15:0] wdata;
    logic [12:0] width;
    int          gap;
    logic        exp_rf;
    logic        exp_wf;
  } vec_t;

  vec_t vecs[8];
  int   widths[7] = '{0, 1, 2, 3, 4, 7, 50};

  initial begin
    logic rf, wf, e;
    int n_f, f_at, n_w, gap, acks;
    logic m;

    vecs[0] = '{1'b1, 26'd440,  16'h0000, 13'd0, 0, 1'b0, 1'b0};
    vecs[1] = '{1'b0, 26'd4400, 16'h1111, 13'd3, 1, 1'b0, 1'b0};
    vecs[2] = '{1'b0, 26'd4401, 16'h2222, 13'd3, 0, 1'b0, 1'b1};
    vecs[3] = '{1'b1, 26'd441,  16'h0000, 13'd1, 0, 1'b1, 1'b0};
    vecs[4] = '{1'b0, 26'd4402, 16'h3333, 13'd1, 2, 1'b0, 1'b0};
    vecs[5] = '{1'b1, 26'd442,  16'h0000, 13'd2, 0, 1'b0, 1'b0};
    vecs[6] = '{1'b1, 26'd443,  16'h0000, 13'd2, 1, 1'b1, 1'b0};
    vecs[7] = '{1'b0, 26'd4403, 16'h4444, 13'd2, 0, 1'b0, 1'b1};

    n_rst = 1'b0; clear = 1'b0; image_width = 13'd0;
    bus.req = 1'b1; bus.req_mode = 1'b1; bus.req_addr = 26'd440; bus.req_wdata = 16'hFFFF;

    // Reset held with req asserted: everything stays zero.
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("reset_ctrl", longint'(ctrl_outs()), 64'd0);
    end
    chk("reset_addr", longint'(bus.sram_addr), 64'd0);
    bus.req = 1'b0;
    n_rst = 1'b1;
    @(negedge clk);
    chk("post_reset_idle", longint'(ctrl_outs()), 64'd0);

    // Directed table.
    for (int i = 0; i < 8; i++) begin
      repeat (vecs[i].gap) @(negedge clk);
      image_width = vecs[i].width;
      access(vecs[i].mode, vecs[i].addr, vecs[i].wdata, vecs[i].exp_rf, vecs[i].exp_wf, rf, wf);
    end
    clear_pulse();

    // Full row of streamed reads, then one more.
    image_width = 13'd50; n_f = 0; f_at = 0;
    for (int i = 1; i <= 51; i++) begin
      e = row_step(1'b1, 50);
      access(1'b1, 26'(1000 + i), 16'h0, e, 1'b0, rf, wf);
      if (rf) begin n_f++; f_at = i; end
    end
    chk("row_rd_flag_count", longint'(n_f), 64'd1);
    chk("row_rd_flag_at", longint'(f_at), 64'd50);

    // Full row of streamed writes.
    clear_pulse();
    n_f = 0; f_at = 0;
    for (int i = 1; i <= 50; i++) begin
      e = row_step(1'b0, 50);
      access(1'b0, 26'(4400 + i - 1), 16'(i * 3), 1'b0, e, rf, wf);
      if (wf) begin n_f++; f_at = i; end
    end
    chk("row_wr_flag_count", longint'(n_f), 64'd1);
    chk("row_wr_flag_at", longint'(f_at), 64'd49);

    // Width 1: every read flags and no write flags.
    clear_pulse();
    image_width = 13'd1; n_f = 0; n_w = 0;
    for (int i = 0; i < 6; i++) begin
      m = (i < 3);
      e = row_step(m, 1);
      access(m, 26'(700 + i), 16'(i), m ? e : 1'b0, m ? 1'b0 : e, rf, wf);
      if (rf) n_f++;
      if (wf) n_w++;
    end
    chk("w1_rd_flags", longint'(n_f), 64'd3);
    chk("w1_wr_flags", longint'(n_w), 64'd0);

    // Abort a read on its last strobe cycle.
    clear_pulse();
    image_width = 13'd2;
    e = row_step(1'b1, 2);
    access(1'b1, 26'd500, 16'h0, e, 1'b0, rf, wf);
    bus.req = 1'b1; bus.req_mode = 1'b1; bus.req_addr = 26'd501;
    @(negedge clk);
    chk("abort_issue_strobe", longint'(bus.sram_read_enable), 64'd1);
    @(negedge clk);
    chk("abort_wait_strobe", longint'(bus.sram_read_enable), 64'd1);
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0; bus.req = 1'b0;
    chk("abort_strobe_low", longint'({bus.sram_read_enable, bus.busy}), 64'd0);
    chk("abort_no_ack", longint'(bus.ack), 64'd0);
    chk("abort_rd_kept", longint'(bus.rd_data), longint'(m_rd_data));
    acks = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (bus.ack === 1'b1 || bus.calc_enable === 1'b1) acks++;
    end
    chk("abort_no_late_ack", longint'(acks), 64'd0);
    m_rd_cnt = 0; m_wr_cnt = 0;
    e = row_step(1'b1, 2);
    access(1'b1, 26'd502, 16'h0, e, 1'b0, rf, wf);
    @(negedge clk);

    // clear overrides a request in IDLE.
    clear = 1'b1; bus.req = 1'b1; bus.req_mode = 1'b0; bus.req_addr = 26'd9;
    @(negedge clk);
    chk("clear_over_req", longint'(bus.busy), 64'd0);
    clear = 1'b0; bus.req = 1'b0;
    m_rd_cnt = 0; m_wr_cnt = 0;
    @(negedge clk);

    // Reset in the middle of a read clears rd_data and calc_mode too.
    e = row_step(1'b1, 2);
    access(1'b1, 26'd600, 16'h0, e, 1'b0, rf, wf);
    bus.req = 1'b1; bus.req_mode = 1'b1; bus.req_addr = 26'd601;
    @(negedge clk);
    n_rst = 1'b0; bus.req = 1'b0;
    @(negedge clk);
    chk("midrst_ctrl", longint'(ctrl_outs()), 64'd0);
    chk("midrst_addr", longint'(bus.sram_addr), 64'd0);
    n_rst = 1'b1;
    m_rd_data = 16'h0; m_rd_cnt = 0; m_wr_cnt = 0;
    @(negedge clk);
    e = row_step(1'b0, 2);
    access(1'b0, 26'd602, 16'hA5A5, 1'b0, e, rf, wf);

    // Randomized accesses with width changes, idle gaps and clears.
    for (int i = 0; i < 300; i++) begin
      if (i % 10 == 0) image_width = 13'(widths[$urandom_range(0, 6)]);
      gap = $urandom_range(0, 4);
      if (gap == 4) clear_pulse();
      else repeat (gap) @(negedge clk);
      m = 1'($urandom);
      e = row_step(m, int'(image_width));
      access(m, 26'($urandom), 16'($urandom), m ? e : 1'b0, m ? 1'b0 : e, rf, wf);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end
endmodule
